// File: rtl/seq_pattern_detector_pkg.sv
// seq_pattern_detector_pkg: shared state encoding and default sizes for the pattern detector
package seq_pattern_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        HIT   = 2'b10
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/seq_hit_counter.sv
// seq_hit_counter: saturating match counter, clear takes effect before the increment
module seq_hit_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    // clear-then-increment, holding at all-ones instead of wrapping
    always_comb count_d = clr_i ? W'(inc_i) : (inc_i && !(&count_q)) ? count_q + 1'b1 : count_q;

    // count register
    always_ff @(posedge clk) count_q <= reset ? '0 : count_d;

    assign count_o = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: run-time configurable Moore serial-pattern detector with hit counter;
// define SEQ_PATTERN_DETECTOR_STICKY_IRQ_EN to add the sticky irq/irq_clr pair
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic               armed,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   hit_count
`ifdef SEQ_PATTERN_DETECTOR_STICKY_IRQ_EN
    ,
    input  logic               irq_clr,
    output logic               irq
`endif
);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, mask, hist_n;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d, fill_n;
    logic               ovl_q, ovl_d, err_q, err_d, load_ok, match;

    for (genvar k = 0; k < MAX_LEN; k++) begin : g_mask
        assign mask[k] = LEN_W'(k) < len_q;
    end

    assign load_ok = cfg_load && cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
    assign hist_n  = {hist_q[MAX_LEN-2:0], in_bit};
    assign fill_n  = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
    assign match   = !cfg_load && in_valid && state_q != IDLE && fill_n == len_q
                     && ((hist_n ^ pat_q) & mask) == '0;

    // next-state: config load wins, otherwise shift the history while armed
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        err_d   = 1'b0;
        if (cfg_load) begin
            state_d = load_ok ? ARMED : IDLE;
            err_d   = !load_ok;
            if (load_ok) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end
        end else if (state_q != IDLE) begin
            state_d = match ? HIT : ARMED;
            if (in_valid) begin
                hist_d = hist_n;
                fill_d = (match && !ovl_q) ? '0 : fill_n;
            end
        end
    end

    // state and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            err_q   <= err_d;
        end
    end

    seq_hit_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr || load_ok),
        .inc_i  (match),
        .count_o(hit_count)
    );

    assign out     = state_q == HIT;
    assign armed   = state_q != IDLE;
    assign cfg_err = err_q;

`ifdef SEQ_PATTERN_DETECTOR_STICKY_IRQ_EN
    logic irq_q;

    // sticky interrupt: a match outranks a simultaneous clear, a new config clears it
    always_ff @(posedge clk) begin
        if (reset || load_ok)
            irq_q <= 1'b0;
        else if (match)
            irq_q <= 1'b1;
        else if (irq_clr)
            irq_q <= 1'b0;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: vector table and hand sequences checked through an expected-value queue
module tb_seq_pattern_detector;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        out, armed, cfg_err, out2, armed2, cfg_err2;
    logic [15:0] hit_count;
    logic [1:0]  hit_count2;

    always #5 clk = ~clk;

    seq_pattern_detector #(.MAX_LEN(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out), .armed(armed), .cfg_err(cfg_err), .hit_count(hit_count)
    );

    seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .out(out2), .armed(armed2), .cfg_err(cfg_err2), .hit_count(hit_count2)
    );

    typedef struct {
        logic        rst, cl;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic        ovl, v, b, clr;
        logic        out, arm, err;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic        out, arm, err;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   pass_n = 0;
    int   total_n = 0;

    function automatic vec_t mk(logic rst, logic cl, logic [7:0] pat, logic [3:0] len, logic ovl,
                                logic v, logic b, logic clr, logic eo, logic ea, logic ee, logic [15:0] ec);
        vec_t t;
        t.rst = rst; t.cl = cl; t.pat = pat; t.len = len; t.ovl = ovl;
        t.v = v; t.b = b; t.clr = clr; t.out = eo; t.arm = ea; t.err = ee; t.cnt = ec;
        return t;
    endfunction

    function automatic vec_t bv(logic v, logic b, logic clr, logic eo, logic ea, logic ee, logic [15:0] ec);
        return mk(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, v, b, clr, eo, ea, ee, ec);
    endfunction

    function automatic vec_t ld(logic [7:0] pat, logic [3:0] len, logic ovl, logic v, logic b,
                                logic eo, logic ea, logic ee, logic [15:0] ec);
        return mk(1'b0, 1'b1, pat, len, ovl, v, b, 1'b0, eo, ea, ee, ec);
    endfunction

    function automatic vec_t rv();
        return mk(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total_n++;
        if (act === req) pass_n++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    task automatic step(input vec_t t, input int idx);
        exp_t e;
        reset = t.rst; cfg_load = t.cl; cfg_pattern = t.pat; cfg_len = t.len;
        cfg_overlap = t.ovl; in_valid = t.v; in_bit = t.b; cnt_clr = t.clr;
        sb.push_back('{t.out, t.arm, t.err, t.cnt});
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            total_n++;
            $display("FAIL scoreboard[%0d]: got empty queue want an entry", idx);
        end else begin
            e = sb.pop_front();
            check($sformatf("out[%0d]", idx), {15'd0, out}, {15'd0, e.out});
            check($sformatf("armed[%0d]", idx), {15'd0, armed}, {15'd0, e.arm});
            check($sformatf("cfg_err[%0d]", idx), {15'd0, cfg_err}, {15'd0, e.err});
            check($sformatf("hit_count[%0d]", idx), hit_count, e.cnt);
            check($sformatf("hit_count_w2[%0d]", idx), {14'd0, hit_count2}, (e.cnt > 16'd3) ? 16'd3 : e.cnt);
        end
    endtask

    initial begin
        logic [7:0] p;
        {reset, in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr} = '0;
        cfg_pattern = '0;
        cfg_len = '0;

        tbl.push_back(rv());
        for (int i = 0; i < 4; i++) tbl.push_back(bv(1, i != 3, 0, 0, 0, 0, 0));

        tbl.push_back(ld(8'h05, 3, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 1, 1, 0, 1));
        tbl.push_back(bv(1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(bv(1, 1, 0, 1, 1, 0, 2));
        tbl.push_back(bv(0, 0, 0, 0, 1, 0, 2));

        tbl.push_back(ld(8'h05, 3, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 1, 1, 0, 1));
        tbl.push_back(bv(1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(bv(1, 1, 0, 0, 1, 0, 1));

        p = 8'hA5;
        tbl.push_back(ld(p, 8, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 7; i >= 0; i--) tbl.push_back(bv(1, p[i], 0, i == 0, 1, 0, (i == 0) ? 16'd1 : 16'd0));
        tbl.push_back(bv(0, 0, 0, 0, 1, 0, 1));

        tbl.push_back(ld(8'h01, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 1, 1, 0, 1));
        tbl.push_back(bv(1, 1, 0, 1, 1, 0, 2));
        tbl.push_back(bv(1, 0, 0, 0, 1, 0, 2));

        tbl.push_back(ld(8'h05, 3, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(ld(8'h05, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(bv(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(ld(8'hFF, 9, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(bv(1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(bv(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 0, 0, 0));

        tbl.push_back(ld(8'h03, 2, 1, 1, 1, 0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 1, 1, 0, 1));
        tbl.push_back(bv(1, 1, 0, 1, 1, 0, 2));
        tbl.push_back(bv(1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(bv(0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(bv(1, 1, 0, 1, 1, 0, 1));

        foreach (tbl[i]) step(tbl[i], i);

        step(ld(8'h03, 2, 1, 0, 0, 0, 1, 0, 0), 100);
        for (int i = 0; i < 6; i++) step(bv(1, 1, 0, i != 0, 1, 0, 16'(i)), 101 + i);
        step(rv(), 107);
        step(bv(1, 1, 0, 0, 0, 0, 0), 108);

        step(ld(8'h05, 3, 1, 0, 0, 0, 1, 0, 0), 200);
        step(bv(1, 1, 0, 0, 1, 0, 0), 201);
        step(bv(0, 0, 0, 0, 1, 0, 0), 202);
        step(bv(1, 0, 0, 0, 1, 0, 0), 203);
        step(bv(0, 1, 0, 0, 1, 0, 0), 204);
        step(bv(1, 1, 0, 1, 1, 0, 1), 205);
        step(bv(0, 0, 0, 0, 1, 0, 1), 206);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised Moore serial-pattern detector; the successor to the fixed 3-state Moore detectors in the control path.
- Pattern (1..MAX_LEN bits), length and overlap mode are loaded at run time through a config pulse.
- Counts matches in a saturating hit counter.
- Sits between a serial bit source (valid-qualified) and the status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len / fill counter.
- CNT_W, 16, hit counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  qualifies in_bit this cycle
- in_bit  input  1  serial data bit
- cfg_load  input  1  one-cycle pulse: load cfg_* fields
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit 0 is the last
- cfg_len  input  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  input  1  1 = overlapping matches allowed
- cnt_clr  input  1  clear hit counter
- out  output  1  Moore match flag (state == HIT)
- armed  output  1  state != IDLE
- cfg_err  output  1  one-cycle pulse on illegal cfg_len
- hit_count  output  CNT_W  saturating match count

Behaviour:
- Reset values: state IDLE; out 0; armed 0; cfg_err 0; hit_count 0; history 0; fill 0; pattern, len and overlap registers 0.
- States are IDLE, ARMED and HIT. All outputs are registered or decoded from the state only; no combinational path from in_bit to out.
- cfg_load handling:
  - Legal cfg_len: latch pattern, len and overlap; clear history and fill; clear hit_count; next state ARMED.
  - cfg_len = 0 or cfg_len > MAX_LEN: registers unchanged; next state IDLE; cfg_err = 1 next cycle.
  - cfg_load has priority over in_valid in the same cycle; that in_bit is dropped.
- IDLE: in_valid ignored; leaves only on a legal cfg_load.
- ARMED/HIT with in_valid = 1:
  - hist_n = {hist[MAX_LEN-2:0], in_bit}; fill_n = min(fill+1, len).
  - match = (fill_n == len) && (hist_n[len-1:0] == pattern[len-1:0]).
  - match: next state HIT. Otherwise: next state ARMED.
- ARMED/HIT with in_valid = 0: history and fill hold; next state ARMED, so HIT lasts exactly one cycle per match.
- Latency: out rises in the cycle after the clock edge that sampled the completing bit.
- Back-to-back matches (overlap mode, e.g. pattern "11" with a continuous 1-stream) keep out high on consecutive cycles, one count per cycle.
- Overlap control:
  - cfg_overlap = 1: fill stays saturated after a match.
  - cfg_overlap = 0: fill is cleared on a match, so the next match needs len fresh bits.
- hit_count:
  - +1 on every match cycle; saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr and match in the same cycle → hit_count = 1.
  - cnt_clr alone → 0.
  - A legal cfg_load also clears hit_count; it overrides cnt_clr and match.
- Reset asserted mid-stream: everything returns to reset values next edge; a detector already in HIT drops out to 0.

Optional Feature:
- Macro: SEQ_PATTERN_DETECTOR_STICKY_IRQ_EN.
- When defined: adds output irq (1 bit) and input irq_clr (1 bit).
  - irq is set on any match and held until irq_clr.
  - irq_clr and match in the same cycle → irq stays 1.
  - Reset value 0; a legal cfg_load clears irq.
- When undefined: neither port exists; behaviour otherwise identical.

Decomposition:
- Package seq_pattern_detector_pkg holds:
  - state_t enum logic [1:0] {IDLE=2'b00, ARMED=2'b01, HIT=2'b10}
  - default MAX_LEN and CNT_W constants
- One sub-module: seq_hit_counter, a CNT_W saturating counter with clr/inc inputs, clear-then-increment priority and a sync reset.

Test Plan:
- Reset, then in_valid pulses with no cfg_load → out 0, armed 0, hit_count 0 throughout.
- Load pattern 3'b101, len 3, overlap 1; feed 1,0,1,0,1 → out high one cycle after the 3rd and 5th bits; hit_count = 2.
- Same pattern with overlap 0; feed 1,0,1,0,1 → one match only (3rd bit); hit_count = 1.
- Pattern 2'b11, len 2, overlap 1, CNT_W = 2; feed six 1s → out high for 5 consecutive cycles; hit_count saturates at 3.
- cfg_load with cfg_len = 0, then with cfg_len = MAX_LEN+1 → cfg_err pulses each time; state IDLE; previous pattern retained. cnt_clr coincident with a match → hit_count = 1.
- Assert reset while in HIT with hit_count = 5 → next cycle out 0, armed 0, hit_count 0; in_valid gaps inside a pattern (1,gap,0,gap,1 for 3'b101) still produce a match.
